fifo_wptr_full: RTL

Write-side pointer and full-flag controller for the team's asynchronous FIFO. It sequences the write port of the dual-port FIFO memory: it gates write requests, generates the binary write address, and produces the Gray-coded write pointer handed to the read-domain double-flop synchronizer. It also compares against the read pointer, already synchronized into this domain, to produce full, almost-full, level and overflow status. Everything runs in the write clock domain; the read-side counterpart is a separate block.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/gray_to_bin.sv | 23 ++
 rtl/fifo_wptr_full.sv | 116 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the asynchronous FIFO pointer controllers (write and
// read side). Provides the pointer-width derivation and the binary/Gray
// conversion functions. Functions operate on 32-bit values; callers
// zero-extend and truncate to their own pointer width.
// ---------------------------------------------------------------------------
package fifo_pkg;

    // Pointer width: one extra bit above the address distinguishes full from
    // empty when the address bits of both pointers match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = 32'd0;
        for (int i = 0; i < 32; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// ---------------------------------------------------------------------------
// gray_to_bin
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Ports:
//   i_gray  W-bit Gray-coded value
//   o_bin   W-bit binary equivalent
// ---------------------------------------------------------------------------
module gray_to_bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Bit i of the result is the parity of every Gray bit from i upward.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < W; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// fifo_wptr_full
// Write-domain pointer and status controller of the asynchronous FIFO.
// Gates write requests, produces the binary write address and the Gray
// write pointer for the read-domain synchronizer, and derives full,
// almost-full, occupancy and sticky overflow from the synchronized read
// pointer. Level and full are pessimistic since the read pointer lags.
// Ports:
//   i_clk          write clock
//   i_rst          synchronous active-high reset
//   i_w_inc        write request from producer
//   i_clr_ovf      clears the sticky overflow flag
//   i_rq2_rptr     Gray read pointer, synchronized into this domain
//   o_w_en         memory write enable (combinational)
//   o_w_addr       binary memory write address
//   o_wptr         registered Gray write pointer
//   o_full         registered full flag
//   o_almost_full  registered, level >= AFULL_THRESH
//   o_w_level      registered occupancy 0..DEPTH
//   o_overflow     sticky: write requested while full
// ---------------------------------------------------------------------------
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter  int DEPTH        = 8,
    parameter  int AFULL_THRESH = DEPTH - 2,
    localparam int ADDR_WIDTH   = $clog2(DEPTH),
    localparam int PTR_W        = ptr_width(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_w_inc,
    input  logic                  i_clr_ovf,
    input  logic [PTR_W-1:0]      i_rq2_rptr,
    output logic                  o_w_en,
    output logic [ADDR_WIDTH-1:0] o_w_addr,
    output logic [PTR_W-1:0]      o_wptr,
    output logic                  o_full,
    output logic                  o_almost_full,
    output logic [PTR_W-1:0]      o_w_level,
    output logic                  o_overflow
);

    logic [PTR_W-1:0] r_wbin;
    logic [PTR_W-1:0] r_wptr;
    logic             r_full;
    logic             r_almost_full;
    logic [PTR_W-1:0] r_w_level;
    logic             r_overflow;

    logic             w_w_en;
    logic [PTR_W-1:0] w_bin_next;
    logic [PTR_W-1:0] w_gray_next;
    logic [PTR_W-1:0] w_rptr_full_cmp;
    logic [PTR_W-1:0] w_rbin;
    logic [PTR_W-1:0] w_level_next;
    logic             w_full_next;
    logic             w_afull_next;

    gray_to_bin #(
        .W (PTR_W)
    ) u_rptr_g2b (
        .i_gray (i_rq2_rptr),
        .o_bin  (w_rbin)
    );

    // Uses the registered full so a write into the last slot cannot be
    // followed by another accepted write in the next cycle.
    assign w_w_en = i_w_inc & ~r_full & ~i_rst;

    // Natural modulo-2^PTR_W wrap of the binary pointer is intended.
    assign w_bin_next  = r_wbin + {{(PTR_W-1){1'b0}}, w_w_en};
    assign w_gray_next = PTR_W'(bin2gray(32'(w_bin_next)));

    // Full when the write pointer is exactly one lap ahead: in Gray code
    // that means the top two bits differ and the rest match.
    assign w_rptr_full_cmp = {~i_rq2_rptr[PTR_W-1:PTR_W-2], i_rq2_rptr[PTR_W-3:0]};
    assign w_full_next     = (w_gray_next == w_rptr_full_cmp);

    assign w_level_next = w_bin_next - w_rbin;
    assign w_afull_next = (w_level_next >= PTR_W'(AFULL_THRESH));

    // Pointer and status registers; overflow set has priority over clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wbin        <= '0;
            r_wptr        <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_w_level     <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_bin_next;
            r_wptr        <= w_gray_next;
            r_full        <= w_full_next;
            r_almost_full <= w_afull_next;
            r_w_level     <= w_level_next;
            if (i_w_inc & r_full) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    assign o_w_en        = w_w_en;
    assign o_w_addr      = r_wbin[ADDR_WIDTH-1:0];
    assign o_wptr        = r_wptr;
    assign o_full        = r_full;
    assign o_almost_full = r_almost_full;
    assign o_w_level     = r_w_level;
    assign o_overflow    = r_overflow;

endmodule
